// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: ROM address/data, the valid/ready instruction
// stream, and the redirect/halt controls. "master" is the fetch unit's
// side of the bundle; "slave" is the side seen by the ROM and the consumer.
interface instr_fetch_unit_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 15
);
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] rom_data;
  logic                  inst_valid;
  logic                  inst_ready;
  logic [DATA_WIDTH-1:0] inst_data;
  logic [ADDR_WIDTH-1:0] inst_addr;
  logic                  redirect_en;
  logic                  redirect_rel;
  logic [ADDR_WIDTH-1:0] redirect_target;
  logic                  halt;
  logic                  halted;

  modport master (
    output rom_addr,
    input  rom_data,
    output inst_valid,
    input  inst_ready,
    output inst_data,
    output inst_addr,
    input  redirect_en,
    input  redirect_rel,
    input  redirect_target,
    input  halt,
    output halted
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    input  inst_valid,
    output inst_ready,
    input  inst_data,
    input  inst_addr,
    output redirect_en,
    output redirect_rel,
    output redirect_target,
    output halt,
    input  halted
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch sequencer: a stallable, redirectable program counter
// that drives a synchronous ROM and presents a valid/ready instruction
// stream tagged with each word's address. A one-word skid buffer catches
// the ROM word that is already in flight when the consumer stalls, so no
// word is ever lost.
module instr_fetch_unit #(
  parameter int          ADDR_WIDTH = 8,
  parameter int          DATA_WIDTH = 15,
  parameter int unsigned RESET_ADDR = 0,
  parameter bit          WRAP_EN    = 1'b1
) (
  input logic                 clock,
  input logic                 reset,
  instr_fetch_unit_if.master  bus
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] MAX_ADDR = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] RST_ADDR = ADDR_WIDTH'(RESET_ADDR);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic                  pending_q, pending_d;
  logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
  logic                  skid_valid_q, skid_valid_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic [ADDR_WIDTH-1:0] skid_addr_q, skid_addr_d;

  logic                  accept_s;
  logic                  redirect_s;
  logic                  issue_s;
  logic                  last_s;
  logic [ADDR_WIDTH-1:0] target_s;

  // Next-state logic: redirect, output/skid steering, fetch issue and FSM.
  always_comb begin
    state_d      = state_q;
    rom_addr_d   = rom_addr_q;
    pending_d    = pending_q;
    pend_addr_d  = pend_addr_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_addr_d   = out_addr_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_addr_d  = skid_addr_q;

    accept_s   = out_valid_q & bus.inst_ready;
    // halt takes priority over a simultaneous redirect
    redirect_s = bus.redirect_en & ~bus.halt;
    last_s     = (WRAP_EN == 1'b0) && (rom_addr_q == MAX_ADDR);

    if (bus.redirect_rel) begin
      target_s = out_addr_q + bus.redirect_target;
    end else begin
      target_s = bus.redirect_target;
    end

    // A full skid being drained this cycle frees its slot, so the next
    // fetch can go out without leaving a bubble after a stall.
    issue_s = (state_q == ST_RUN) && (!skid_valid_q || accept_s) &&
              !(pending_q && out_valid_q && !bus.inst_ready);

    if (redirect_s) begin
      // squash everything in flight, including the current output word
      rom_addr_d   = target_s;
      pending_d    = 1'b0;
      skid_valid_d = 1'b0;
      out_valid_d  = 1'b0;
      state_d      = ST_RUN;
    end else begin
      if (!out_valid_q || accept_s) begin
        if (skid_valid_q) begin
          out_valid_d  = 1'b1;
          out_data_d   = skid_data_q;
          out_addr_d   = skid_addr_q;
          skid_valid_d = 1'b0;
        end else if (pending_q) begin
          out_valid_d = 1'b1;
          out_data_d  = bus.rom_data;
          out_addr_d  = pend_addr_q;
        end else begin
          out_valid_d = 1'b0;
        end
      end else begin
        // output held: an arriving ROM word parks in the skid
        if (pending_q) begin
          skid_valid_d = 1'b1;
          skid_data_d  = bus.rom_data;
          skid_addr_d  = pend_addr_q;
        end else begin
          skid_valid_d = skid_valid_q;
        end
      end

      pending_d = issue_s;
      if (issue_s) begin
        pend_addr_d = rom_addr_q;
        if (last_s) begin
          rom_addr_d = rom_addr_q;
        end else begin
          rom_addr_d = rom_addr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        end
      end else begin
        pend_addr_d = pend_addr_q;
      end

      if (bus.halt) begin
        state_d = ST_HALT;
      end else if (issue_s && last_s) begin
        state_d = ST_HALT;
      end else begin
        state_d = state_q;
      end
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_RUN;
      rom_addr_q   <= RST_ADDR;
      pending_q    <= 1'b0;
      pend_addr_q  <= RST_ADDR;
      out_valid_q  <= 1'b0;
      out_data_q   <= {DATA_WIDTH{1'b0}};
      out_addr_q   <= RST_ADDR;
      skid_valid_q <= 1'b0;
      skid_data_q  <= {DATA_WIDTH{1'b0}};
      skid_addr_q  <= RST_ADDR;
    end else begin
      state_q      <= state_d;
      rom_addr_q   <= rom_addr_d;
      pending_q    <= pending_d;
      pend_addr_q  <= pend_addr_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_addr_q   <= out_addr_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_addr_q  <= skid_addr_d;
    end
  end

  assign bus.rom_addr   = rom_addr_q;
  assign bus.inst_valid = out_valid_q;
  assign bus.inst_data  = out_data_q;
  assign bus.inst_addr  = out_addr_q;
  assign bus.halted     = (state_q == ST_HALT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit. dut0 wraps at end of memory,
// dut1 stops there. Each ROM holds ROM[i] = i + 100.
module tb_instr_fetch_unit;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  instr_fetch_unit_if #(.ADDR_WIDTH(8), .DATA_WIDTH(15)) bus0 ();
  instr_fetch_unit_if #(.ADDR_WIDTH(8), .DATA_WIDTH(15)) bus1 ();

  instr_fetch_unit #(.ADDR_WIDTH(8), .DATA_WIDTH(15), .RESET_ADDR(0), .WRAP_EN(1'b1)) dut0 (
    .clock(clock), .reset(reset), .bus(bus0));
  instr_fetch_unit #(.ADDR_WIDTH(8), .DATA_WIDTH(15), .RESET_ADDR(0), .WRAP_EN(1'b0)) dut1 (
    .clock(clock), .reset(reset), .bus(bus1));

  // synchronous ROM models
  always @(posedge clock) begin
    bus0.rom_data <= 15'(bus0.rom_addr) + 15'd100;
    bus1.rom_data <= 15'(bus1.rom_addr) + 15'd100;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // drive a one-cycle redirect on dut0 (no checking here)
  task automatic pulse_redirect0(input logic rel, input logic [7:0] tgt);
    bus0.redirect_en     = 1'b1;
    bus0.redirect_rel    = rel;
    bus0.redirect_target = tgt;
    step();
    bus0.redirect_en  = 1'b0;
    bus0.redirect_rel = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clock);
    #1;
    checks++; if (bus0.inst_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0h exp 0", bus0.inst_valid); end
    checks++; if (bus0.inst_addr !== 8'h00) begin errors++; $display("FAIL rst_addr got %0h exp 0", bus0.inst_addr); end
    checks++; if (bus0.inst_data !== 15'd0) begin errors++; $display("FAIL rst_data got %0h exp 0", bus0.inst_data); end
    checks++; if (bus0.rom_addr !== 8'h00) begin errors++; $display("FAIL rst_rom_addr got %0h exp 0", bus0.rom_addr); end
    checks++; if (bus0.halted !== 1'b0) begin errors++; $display("FAIL rst_halted got %0h exp 0", bus0.halted); end
    reset = 1'b1;
    step();
    checks++; if (bus0.inst_valid !== 1'b0) begin errors++; $display("FAIL first_edge_valid got %0h exp 0", bus0.inst_valid); end
    step();
  endtask

  task automatic test_stream();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus0.inst_valid !== 1'b1 || bus0.inst_addr !== 8'(i) || bus0.inst_data !== 15'(i + 100)) begin
        errors++;
        $display("FAIL stream[%0d] got v=%0h a=%0h d=%0d exp v=1 a=%0h d=%0d",
                 i, bus0.inst_valid, bus0.inst_addr, bus0.inst_data, i, i + 100);
      end
      step();
    end
  endtask

  task automatic test_stall();
    bus0.inst_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus0.inst_valid !== 1'b1 || bus0.inst_addr !== 8'h04 || bus0.inst_data !== 15'd104) begin
        errors++;
        $display("FAIL stall_hold[%0d] got v=%0h a=%0h d=%0d exp v=1 a=4 d=104",
                 i, bus0.inst_valid, bus0.inst_addr, bus0.inst_data);
      end
    end
    bus0.inst_ready = 1'b1;
    for (int i = 5; i < 8; i++) begin
      step();
      checks++;
      if (bus0.inst_valid !== 1'b1 || bus0.inst_addr !== 8'(i) || bus0.inst_data !== 15'(i + 100)) begin
        errors++;
        $display("FAIL stall_resume got v=%0h a=%0h d=%0d exp v=1 a=%0h d=%0d",
                 bus0.inst_valid, bus0.inst_addr, bus0.inst_data, i, i + 100);
      end
    end
  endtask

  task automatic test_abs_redirect();
    // address 7 is on the output now
    pulse_redirect0(1'b0, 8'h40);
    checks++; if (bus0.inst_valid !== 1'b0) begin errors++; $display("FAIL redir_squash got %0h exp 0", bus0.inst_valid); end
    step();
    checks++; if (bus0.inst_valid !== 1'b0) begin errors++; $display("FAIL redir_gap got %0h exp 0", bus0.inst_valid); end
    step();
    checks++;
    if (bus0.inst_valid !== 1'b1 || bus0.inst_addr !== 8'h40 || bus0.inst_data !== 15'd164) begin
      errors++;
      $display("FAIL redir_abs got v=%0h a=%0h d=%0d exp v=1 a=40 d=164", bus0.inst_valid, bus0.inst_addr, bus0.inst_data);
    end
    step();
    checks++; if (bus0.inst_addr !== 8'h41) begin errors++; $display("FAIL redir_abs_next got %0h exp 41", bus0.inst_addr); end
  endtask

  task automatic test_rel_redirect();
    pulse_redirect0(1'b0, 8'h10);
    repeat (2) step();
    checks++; if (bus0.inst_addr !== 8'h10) begin errors++; $display("FAIL rel_setup got %0h exp 10", bus0.inst_addr); end
    pulse_redirect0(1'b1, 8'hFC);
    repeat (2) step();
    checks++;
    if (bus0.inst_valid !== 1'b1 || bus0.inst_addr !== 8'h0C || bus0.inst_data !== 15'd112) begin
      errors++;
      $display("FAIL rel_back got v=%0h a=%0h d=%0d exp v=1 a=0c d=112", bus0.inst_valid, bus0.inst_addr, bus0.inst_data);
    end
    pulse_redirect0(1'b0, 8'h02);
    repeat (2) step();
    checks++; if (bus0.inst_addr !== 8'h02) begin errors++; $display("FAIL rel_setup2 got %0h exp 02", bus0.inst_addr); end
    pulse_redirect0(1'b1, 8'hFC);
    repeat (2) step();
    checks++;
    if (bus0.inst_valid !== 1'b1 || bus0.inst_addr !== 8'hFE || bus0.inst_data !== 15'd354) begin
      errors++;
      $display("FAIL rel_wrap got v=%0h a=%0h d=%0d exp v=1 a=fe d=354", bus0.inst_valid, bus0.inst_addr, bus0.inst_data);
    end
  endtask

  task automatic test_wrap();
    step();
    checks++;
    if (bus0.inst_valid !== 1'b1 || bus0.inst_addr !== 8'hFF || bus0.inst_data !== 15'd355) begin
      errors++;
      $display("FAIL wrap_max got v=%0h a=%0h d=%0d exp v=1 a=ff d=355", bus0.inst_valid, bus0.inst_addr, bus0.inst_data);
    end
    step();
    checks++;
    if (bus0.inst_valid !== 1'b1 || bus0.inst_addr !== 8'h00 || bus0.inst_data !== 15'd100) begin
      errors++;
      $display("FAIL wrap_zero got v=%0h a=%0h d=%0d exp v=1 a=0 d=100", bus0.inst_valid, bus0.inst_addr, bus0.inst_data);
    end
  endtask

  task automatic test_halt();
    // output=0x00, 0x01 in flight; halt and redirect together
    bus0.halt            = 1'b1;
    bus0.redirect_en     = 1'b1;
    bus0.redirect_target = 8'h80;
    step();
    bus0.halt        = 1'b0;
    bus0.redirect_en = 1'b0;
    checks++; if (bus0.halted !== 1'b1) begin errors++; $display("FAIL halt_flag got %0h exp 1", bus0.halted); end
    checks++;
    if (bus0.inst_valid !== 1'b1 || bus0.inst_addr !== 8'h01) begin
      errors++;
      $display("FAIL halt_drain1 got v=%0h a=%0h exp v=1 a=01", bus0.inst_valid, bus0.inst_addr);
    end
    step();
    checks++;
    if (bus0.inst_valid !== 1'b1 || bus0.inst_addr !== 8'h02 || bus0.inst_data !== 15'd102) begin
      errors++;
      $display("FAIL halt_drain2 got v=%0h a=%0h d=%0d exp v=1 a=02 d=102", bus0.inst_valid, bus0.inst_addr, bus0.inst_data);
    end
    repeat (2) begin
      step();
      checks++;
      if (bus0.inst_valid !== 1'b0 || bus0.halted !== 1'b1) begin
        errors++;
        $display("FAIL halt_idle got v=%0h h=%0h exp v=0 h=1", bus0.inst_valid, bus0.halted);
      end
    end
  endtask

  task automatic test_no_wrap();
    bit found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      if (bus1.inst_valid === 1'b1 && bus1.inst_addr === 8'hFF) found = 1'b1;
      else step();
    end
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL nowrap_timeout got found=%0d exp 1", found); end
    checks++;
    if (bus1.inst_data !== 15'd355 || bus1.halted !== 1'b1) begin
      errors++;
      $display("FAIL nowrap_max got d=%0d h=%0h exp d=355 h=1", bus1.inst_data, bus1.halted);
    end
    repeat (3) begin
      step();
      checks++;
      if (bus1.inst_valid !== 1'b0 || bus1.halted !== 1'b1 || bus1.rom_addr !== 8'hFF) begin
        errors++;
        $display("FAIL nowrap_stop got v=%0h h=%0h ra=%0h exp v=0 h=1 ra=ff", bus1.inst_valid, bus1.halted, bus1.rom_addr);
      end
    end
    bus1.redirect_en     = 1'b1;
    bus1.redirect_target = 8'h20;
    step();
    bus1.redirect_en = 1'b0;
    checks++; if (bus1.halted !== 1'b0) begin errors++; $display("FAIL nowrap_resume_flag got %0h exp 0", bus1.halted); end
    repeat (2) step();
    checks++;
    if (bus1.inst_valid !== 1'b1 || bus1.inst_addr !== 8'h20 || bus1.inst_data !== 15'd132) begin
      errors++;
      $display("FAIL nowrap_resume got v=%0h a=%0h d=%0d exp v=1 a=20 d=132", bus1.inst_valid, bus1.inst_addr, bus1.inst_data);
    end
  endtask

  task automatic test_reset_midop();
    pulse_redirect0(1'b0, 8'h30);
    repeat (2) step();
    checks++;
    if (bus0.inst_valid !== 1'b1 || bus0.inst_addr !== 8'h30) begin
      errors++;
      $display("FAIL midrst_setup got v=%0h a=%0h exp v=1 a=30", bus0.inst_valid, bus0.inst_addr);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (bus0.inst_valid !== 1'b0 || bus0.inst_addr !== 8'h00 || bus0.rom_addr !== 8'h00 || bus0.halted !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async got v=%0h a=%0h ra=%0h h=%0h exp all 0",
               bus0.inst_valid, bus0.inst_addr, bus0.rom_addr, bus0.halted);
    end
    step();
    reset = 1'b1;
    step();
    checks++; if (bus0.inst_valid !== 1'b0) begin errors++; $display("FAIL midrst_lat got %0h exp 0", bus0.inst_valid); end
    step();
    checks++;
    if (bus0.inst_valid !== 1'b1 || bus0.inst_addr !== 8'h00 || bus0.inst_data !== 15'd100) begin
      errors++;
      $display("FAIL midrst_first got v=%0h a=%0h d=%0d exp v=1 a=0 d=100", bus0.inst_valid, bus0.inst_addr, bus0.inst_data);
    end
    step();
    checks++;
    if (bus0.inst_addr !== 8'h01 || bus0.inst_data !== 15'd101) begin
      errors++;
      $display("FAIL midrst_second got a=%0h d=%0d exp a=01 d=101", bus0.inst_addr, bus0.inst_data);
    end
  endtask

  initial begin
    bus0.inst_ready = 1'b1; bus0.redirect_en = 1'b0; bus0.redirect_rel = 1'b0;
    bus0.redirect_target = 8'h00; bus0.halt = 1'b0;
    bus1.inst_ready = 1'b1; bus1.redirect_en = 1'b0; bus1.redirect_rel = 1'b0;
    bus1.redirect_target = 8'h00; bus1.halt = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_abs_redirect();
    test_rel_redirect();
    test_wrap();
    test_halt();
    test_no_wrap();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
